// File: rtl/ena_write_addr_gen_pkg.sv
// rtl/ena_write_addr_gen_pkg.sv - shared state encodings, error bit indices and widths
package ena_write_addr_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  localparam int ERR_OVERRUN = 0;
  localparam int ERR_LENGTH  = 1;
  localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/ena_write_addr_gen_if.sv
// rtl/ena_write_addr_gen_if.sv - window input, RAM write port and bank status bundle
interface ena_write_addr_gen_if
  import ena_write_addr_gen_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic                   ena_write;
  logic [DATA_W-1:0]      din;
  logic                   rd_ack;
  logic                   err_clr;
  logic                   wr_en;
  logic [ADDR_W:0]        wr_addr;
  logic [DATA_W-1:0]      wr_data;
  logic                   frame_done;
  logic                   rd_bank;
  logic [1:0]             bank_full;
  logic [1:0]             err;
  logic [FRAME_CNT_W-1:0] frame_cnt;

  modport master (
    output ena_write, din, rd_ack, err_clr,
    input  wr_en, wr_addr, wr_data, frame_done, rd_bank, bank_full, err, frame_cnt
  );

  modport slave (
    input  ena_write, din, rd_ack, err_clr,
    output wr_en, wr_addr, wr_data, frame_done, rd_bank, bank_full, err, frame_cnt
  );
endinterface

// File: rtl/ena_write_addr_gen_bank_ctrl.sv
// rtl/ena_write_addr_gen_bank_ctrl.sv - ping-pong bank ownership between writer and reader
module ena_write_bank_ctrl (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_frame_ok,
  input  logic       i_rd_ack,
  output logic [1:0] o_bank_full,
  output logic       o_wbank,
  output logic       o_rd_bank,
  output logic       o_overrun
);
  logic [1:0] r_bank_full;
  logic       r_wbank;
  logic       r_rd_bank;
  logic       w_ack_ok;
  logic       w_reader_idle;

  // An ack only counts when the bank the reader holds is actually full.
  assign w_ack_ok      = i_rd_ack && r_bank_full[r_rd_bank];
  assign w_reader_idle = (r_bank_full == 2'b00);

  // Release on ack, claim on frame completion; both may land on the same edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bank_full <= 2'b00;
      r_wbank     <= 1'b0;
      r_rd_bank   <= 1'b0;
    end else begin
      if (w_ack_ok) begin
        r_bank_full[r_rd_bank] <= 1'b0;
      end
      if (i_frame_ok) begin
        r_bank_full[r_wbank] <= 1'b1;
        r_wbank              <= ~r_wbank;
      end
      if (i_frame_ok && w_reader_idle) begin
        r_rd_bank <= r_wbank;
      end else if (w_ack_ok) begin
        r_rd_bank <= ~r_rd_bank;
      end
    end
  end

  assign o_bank_full = r_bank_full;
  assign o_wbank     = r_wbank;
  assign o_rd_bank   = r_rd_bank;
  assign o_overrun   = r_bank_full[r_wbank];
endmodule

// File: rtl/ena_write_addr_gen.sv
// rtl/ena_write_addr_gen.sv - frames enable windows into ping-pong RAM writes (option: ENA_WRITE_FRAME_CNT_EN)
module ena_write_addr_gen
  import ena_write_addr_gen_pkg::*;
#(
  parameter logic [31:0] N_WORDS = 32'd1,
  parameter int          ADDR_W  = 10,
  parameter int          DATA_W  = 32
)(
  input logic                  i_clk,
  input logic                  i_rst,
  ena_write_addr_gen_if.slave  bus
);
  state_t            r_state;
  logic [31:0]       r_cnt;
  logic              r_wr_en;
  logic [ADDR_W:0]   r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_frame_done;
  logic [1:0]        r_err;
  logic              w_frame_ok;
  logic              w_wbank;
  logic              w_overrun;
  logic              w_rd_bank;
  logic [1:0]        w_bank_full;

  // A frame is good only when the window closes with exactly N_WORDS words taken.
  assign w_frame_ok = (r_state == ST_WRITE) && !bus.ena_write && (r_cnt == N_WORDS);

  ena_write_bank_ctrl u_bank_ctrl (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_frame_ok  (w_frame_ok),
    .i_rd_ack    (bus.rd_ack),
    .o_bank_full (w_bank_full),
    .o_wbank     (w_wbank),
    .o_rd_bank   (w_rd_bank),
    .o_overrun   (w_overrun)
  );

  // Window FSM with registered write port, completion pulse and sticky errors.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 32'd0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_frame_done <= 1'b0;
      r_err        <= 2'b00;
    end else begin
      r_wr_en      <= 1'b0;
      r_frame_done <= 1'b0;
      if (bus.err_clr) begin
        r_err <= 2'b00;
      end
      case (r_state)
        ST_IDLE: begin
          if (bus.ena_write) begin
            if (w_overrun) begin
              r_state            <= ST_DROP;
              r_err[ERR_OVERRUN] <= 1'b1;
            end else begin
              r_state   <= ST_WRITE;
              r_wr_en   <= 1'b1;
              r_wr_addr <= {w_wbank, r_cnt[ADDR_W-1:0]};
              r_wr_data <= bus.din;
              r_cnt     <= r_cnt + 32'd1;
            end
          end
        end
        ST_WRITE: begin
          if (bus.ena_write) begin
            if (r_cnt < N_WORDS) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= {w_wbank, r_cnt[ADDR_W-1:0]};
              r_wr_data <= bus.din;
              r_cnt     <= r_cnt + 32'd1;
            end else begin
              r_err[ERR_LENGTH] <= 1'b1;
            end
          end else begin
            r_state <= ST_IDLE;
            r_cnt   <= 32'd0;
            if (r_cnt == N_WORDS) begin
              r_frame_done <= 1'b1;
            end else begin
              r_err[ERR_LENGTH] <= 1'b1;
            end
          end
        end
        ST_DROP: begin
          if (!bus.ena_write) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef ENA_WRITE_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] r_frame_cnt;

  // Completed-frame counter, wraps naturally at its width.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_frame_cnt <= '0;
    end else if (w_frame_ok) begin
      r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
    end
  end

  assign bus.frame_cnt = r_frame_cnt;
`else
  assign bus.frame_cnt = '0;
`endif

  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.frame_done = r_frame_done;
  assign bus.rd_bank    = w_rd_bank;
  assign bus.bank_full  = w_bank_full;
  assign bus.err        = r_err;
endmodule

// File: tb/tb_ena_write_addr_gen.sv
// tb/tb_ena_write_addr_gen.sv - window-level reference model bench for ena_write_addr_gen
module tb_ena_write_addr_gen;
  localparam int N = 4;

`ifdef ENA_WRITE_FRAME_CNT_EN
  localparam bit FCNT_EN = 1'b1;
`else
  localparam bit FCNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  ena_write_addr_gen_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  ena_write_addr_gen #(.N_WORDS(32'd4), .ADDR_W(10), .DATA_W(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [10:0] obs_addr[$];
  logic [31:0] obs_data[$];
  int          obs_cyc[$];
  int          done_total = 0;

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      obs_addr.push_back(bus.wr_addr);
      obs_data.push_back(bus.wr_data);
      obs_cyc.push_back(cyc);
    end
    if (bus.frame_done === 1'b1) done_total <= done_total + 1;
  end

  logic [1:0] m_full;
  logic       m_wbank;
  logic       m_rd;
  logic [1:0] m_err;
  int         m_fcnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_full = 2'b00; m_wbank = 1'b0; m_rd = 1'b0; m_err = 2'b00; m_fcnt = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".bank_full"}, 64'(bus.bank_full), 64'(m_full));
    chk({tag, ".rd_bank"},   64'(bus.rd_bank),   64'(m_rd));
    chk({tag, ".err"},       64'(bus.err),       64'(m_err));
    chk({tag, ".frame_cnt"}, 64'(bus.frame_cnt), FCNT_EN ? 64'(m_fcnt) : 64'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".wr_en"},      64'(bus.wr_en),      64'd0);
    chk({tag, ".wr_addr"},    64'(bus.wr_addr),    64'd0);
    chk({tag, ".wr_data"},    64'(bus.wr_data),    64'd0);
    chk({tag, ".frame_done"}, 64'(bus.frame_done), 64'd0);
    chk({tag, ".rd_bank"},    64'(bus.rd_bank),    64'd0);
    chk({tag, ".bank_full"},  64'(bus.bank_full),  64'd0);
    chk({tag, ".err"},        64'(bus.err),        64'd0);
    chk({tag, ".frame_cnt"},  64'(bus.frame_cnt),  64'd0);
  endtask

  task automatic do_ack(input string tag);
    @(posedge clk); #1;
    bus.rd_ack = 1'b1;
    @(posedge clk); #1;
    bus.rd_ack = 1'b0;
    if (m_full[m_rd]) begin
      m_full[m_rd] = 1'b0;
      m_rd = ~m_rd;
    end
    check_state(tag);
  endtask

  task automatic do_clr(input string tag);
    @(posedge clk); #1;
    bus.err_clr = 1'b1;
    @(posedge clk); #1;
    bus.err_clr = 1'b0;
    m_err = 2'b00;
    check_state(tag);
  endtask

  task automatic run_window(input string tag, input int len, input bit ack_close, input bit clr_start);
    logic [31:0] d[$];
    int          start, base, dbase, nw;
    bit          drop, done;
    logic        wb, old_rd;
    logic [1:0]  old_full;
    base  = obs_addr.size();
    dbase = done_total;
    wb    = m_wbank;
    drop  = m_full[m_wbank];
    start = 0;
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      if (i == 0) start = cyc;
      bus.ena_write = 1'b1;
      bus.din       = $urandom;
      d.push_back(bus.din);
      bus.err_clr   = (i == 0) && clr_start;
    end
    @(posedge clk); #1;
    bus.ena_write = 1'b0;
    bus.err_clr   = 1'b0;
    bus.rd_ack    = ack_close;
    @(posedge clk); #1;
    bus.rd_ack    = 1'b0;
    @(posedge clk); #1;
    if (clr_start) m_err = 2'b00;
    if (drop) m_err[0] = 1'b1;
    else if (len != N) m_err[1] = 1'b1;
    nw   = drop ? 0 : ((len < N) ? len : N);
    done = !drop && (len >= N);
    old_full = m_full;
    old_rd   = m_rd;
    if (ack_close && old_full[old_rd]) begin
      m_full[old_rd] = 1'b0;
      m_rd = ~old_rd;
    end
    if (done) begin
      m_full[wb] = 1'b1;
      if (old_full == 2'b00) m_rd = wb;
      m_wbank = ~wb;
      m_fcnt  = (m_fcnt + 1) % 65536;
    end
    chk({tag, ".wr_count"}, 64'(obs_addr.size() - base), 64'(nw));
    for (int i = 0; i < nw && base + i < obs_addr.size(); i++) begin
      chk({tag, ".wr_addr"}, 64'(obs_addr[base+i]), 64'({wb, 10'(i)}));
      chk({tag, ".wr_data"}, 64'(obs_data[base+i]), 64'(d[i]));
      chk({tag, ".wr_lag"},  64'(obs_cyc[base+i]),  64'(start + 1 + i));
    end
    chk({tag, ".frame_done"}, 64'(done_total - dbase), 64'(done ? 1 : 0));
    check_state(tag);
  endtask

  initial begin
    bus.ena_write = 1'b0;
    bus.din       = '0;
    bus.rd_ack    = 1'b0;
    bus.err_clr   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    run_window("w1_bank0", 4, 1'b0, 1'b0);
    run_window("w2_bank1", 4, 1'b0, 1'b0);
    run_window("w3_overrun", 4, 1'b0, 1'b0);
    do_clr("clr1");
    do_ack("ack_b0");
    do_ack("ack_b1");
    run_window("short3", 3, 1'b0, 1'b0);
    run_window("rewrite4", 4, 1'b0, 1'b0);
    do_clr("clr2");
    run_window("long6", 6, 1'b0, 1'b0);
    do_clr("clr3");
    do_ack("ack_c0");
    do_ack("ack_c1");
    run_window("fill_b0", 4, 1'b0, 1'b0);
    run_window("ack_coincide", 4, 1'b1, 1'b0);
    run_window("fill_b0_again", 4, 1'b0, 1'b0);
    run_window("set_wins_clr", 4, 1'b0, 1'b1);

    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(0, 1) == 1) do_ack("rand_ack");
      run_window("rand_win", $urandom_range(1, 6), 1'($urandom_range(0, 1)), 1'b0);
    end

    @(posedge clk); #1;
    bus.ena_write = 1'b1; bus.din = $urandom;
    @(posedge clk); #1;
    bus.din = $urandom;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.ena_write = 1'b0;
    @(posedge clk); #1;
    check_zero("mid_rst");
    rst = 1'b0;
    model_reset();
    run_window("post_rst1", 4, 1'b0, 1'b0);
    do_ack("post_rst_ack1");
    run_window("post_rst2", 4, 1'b0, 1'b0);
    do_ack("post_rst_ack2");
    run_window("post_rst3", 4, 1'b0, 1'b0);
    chk("three_frames", 64'(bus.frame_cnt), FCNT_EN ? 64'd3 : 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
